clk_divider: RTL and testbench
==============================

// Module: clk_divider
// PURPOSE
//   Free-running binary ripple-rate generator. A WIDTH-bit up-counter advances once per `clock` edge,
//   so bit N toggles at f_clock / 2^(N+1); bit 24 of a 50 MHz clock gives ~1.49 Hz.
//   The block sits at the top level and supplies slow clocks/strobes (e.g. divided_clocks[whichClock]) to game/display logic.
//   It also provides a run-time tap select and a one-cycle rising-edge strobe for the selected tap.
// PARAMETERS
//   WIDTH        32   counter width; divided_clocks[k] has period 2^(k+1) clock cycles
//   DEFAULT_SEL  24   documentation/default tap index for integrators (no effect on logic)
//   SELW         $clog2(WIDTH) (localparam) width of sel
// PORTS
//   clock           in   1         single system clock, all logic on posedge
//   reset           in   1         synchronous, active-high reset
//   enable          in   1         1 = count advances, 0 = counter holds
//   sel             in   SELW      tap index for clk_sel / tick
//   divided_clocks  out  WIDTH     counter value; bit k = clock / 2^(k+1)
//   clk_sel         out  1         divided_clocks[sel] (combinational mux of registered bits)
//   tick            out  1         registered; high for exactly the cycle after divided_clocks[sel] rises
// BEHAVIOUR
//   - One clock, `clock`; reset is synchronous and active-high on `reset`. No other clocks or async paths.
//   - Reset (sampled at posedge): divided_clocks <= 0, tick <= 0; therefore clk_sel = 0. Reset overrides enable.
//   - Reset mid-operation: counter returns to 0 at that edge regardless of value; counting resumes
//     on the first edge with reset=0 and enable=1 (value 1 after that edge).
//   - Count: if enable, divided_clocks <= divided_clocks + 1 (modulo 2^WIDTH); else hold.
//   - Wrap: all-ones -> 0 with no flag, no stall; MSB falls, so tick fires for no tap on the wrap edge.
//   - tick: at each posedge, tick <= enable & ~reset & (divided_clocks[sel] == 0) & (divided_clocks[sel-1:0] all ones)
//     (for sel=0: just divided_clocks[0]==0). So tick == 1 exactly when the edge just set bit sel 0->1,
//     i.e. tick is coincident with the first cycle clk_sel is high. Period of tick = 2^(sel+1) cycles.
//   - tick uses the sel value sampled at the edge; changing sel never yields a spurious tick from the mux
//     switch itself (tick reflects counter increment only); clk_sel may step immediately on a sel change.
//   - sel >= WIDTH (non-power-of-2 WIDTH): clamp to WIDTH-1 for both clk_sel and tick.
//   - enable low: counter frozen, tick = 0 on every such edge, clk_sel static.
//   - Latency: divided_clocks and tick valid 1 cycle after the causing edge; clk_sel same-cycle from sel.
//   - No X propagation: all registers have reset values; outputs defined from the first reset edge.
// STRUCTURE
//   - Shared package (clk_div_pkg): CLK_DIV_WIDTH=32, CLK_DIV_DEFAULT_SEL=24, and a function
//     rise_mask(sel) returning the {0, ones(sel)} compare mask used for tick.
//   - Single module, no sub-modules; counter register, tap mux, tick compare/register.
//   - Integration: top instantiates with WIDTH=32, enable tied 1, sel=whichClock, uses divided_clocks[whichClock].
// TESTING
//   1. Reset: hold reset=1 3 cycles with enable=1 -> divided_clocks=0, tick=0, clk_sel=0 every cycle.
//   2. Count: release reset, enable=1, 16 edges -> divided_clocks=16; bit0 toggles each cycle, bit3 period 16.
//   3. Tick, sel=2: from 0 -> tick high only when count becomes 4, 12, 20 (period 8), one cycle wide, clk_sel rising at same cycles.
//   4. Enable: count to 5, enable=0 for 4 edges -> stays 5, tick=0; enable=1 -> 6 next edge.
//   5. Wrap: WIDTH=4, sel=3, run 20 edges -> 15 -> 0 wrap with tick=0 on wrap; tick at count 8 and 24-mod-16=8 (period 16).
//   6. Mid-op reset and sel change: at count 0x1F assert reset one cycle -> 0, tick=0; sel 0->4 at count 3 -> clk_sel=0, no tick until count 16.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and the tap compare-mask helper for the clock divider.
package clk_div_pkg;

   localparam int CLK_DIV_WIDTH       = 32;
   localparam int CLK_DIV_DEFAULT_SEL = 24;

   // Returns a mask with the low `sel` bits set and bit `sel` (and above) clear.
   // A counter whose low sel+1 bits equal rise_mask(sel) will set bit sel on its next increment.
   function automatic logic [CLK_DIV_WIDTH-1:0] rise_mask(input int unsigned sel);
      logic [CLK_DIV_WIDTH-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < CLK_DIV_WIDTH; i++) begin
         m[i] = (i < sel);
      end
      return m;
   endfunction

endpackage

// File: rtl/clk_divider.sv
// Free-running binary rate generator: a WIDTH-bit up-counter whose bit k has period 2^(k+1)
// clocks, plus a run-time tap select (clk_sel) and a registered one-cycle rising strobe (tick).
//
// Handshake: none. `enable` is a level qualifier, not a valid/ready pair: every posedge with
// enable=1 and reset=0 advances the counter; enable=0 freezes it and forces tick low.
module clk_divider
   import clk_div_pkg::*;
#(
   parameter int  WIDTH       = CLK_DIV_WIDTH,
   parameter int  DEFAULT_SEL = CLK_DIV_DEFAULT_SEL,
   localparam int SELW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [SELW-1:0]  sel,
   output logic [WIDTH-1:0] divided_clocks,
   output logic             clk_sel,
   output logic             tick
);

   // Elaboration-time sanity on parameters; the mask helper is sized to the package width.
   if (WIDTH < 1 || WIDTH > CLK_DIV_WIDTH) begin : g_bad_width
      $error("clk_divider: WIDTH must be in 1..%0d", CLK_DIV_WIDTH);
   end
   if (DEFAULT_SEL < 0 || DEFAULT_SEL >= WIDTH) begin : g_bad_default_sel
      $error("clk_divider: DEFAULT_SEL must be a valid tap index");
   end

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic [SELW-1:0]  sel_eff;
   logic [WIDTH-1:0] low_mask;
   logic [WIDTH-1:0] care_mask;
   logic             rise_hit;

   // Out-of-range taps (possible when WIDTH is not a power of two) clamp to the MSB.
   assign sel_eff = (int'(sel) > WIDTH - 1) ? SELW'(WIDTH - 1) : sel;

   // low_mask: ones below the tap, zero at the tap; care_mask: tap bit and everything below it.
   assign low_mask  = WIDTH'(rise_mask(32'(sel_eff)));
   assign care_mask = WIDTH'(rise_mask(32'(sel_eff) + 32'd1));

   // The next increment will carry into the tap bit, i.e. the tap goes 0->1 on this edge.
   assign rise_hit = ((cnt_q & care_mask) == low_mask);

   // Next-state: advance when enabled; tick only fires on an edge that really increments.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (enable) begin
         cnt_d  = cnt_q + WIDTH'(1);
         tick_d = rise_hit;
      end
   end

   // State registers with synchronous reset overriding enable.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign divided_clocks = cnt_q;
   assign clk_sel        = cnt_q[sel_eff];
   assign tick           = tick_q;

endmodule

// File: tb/tb_clk_divider.sv
// Directed testbench for clk_divider: three instances (WIDTH=32, 4 and 5) share clock,
// reset and enable; each has its own tap select.
module tb_clk_divider;

   logic        clock;
   logic        reset;
   logic        enable;

   logic [4:0]  sel_a;
   logic [31:0] dc_a;
   logic        cs_a, tk_a;

   logic [1:0]  sel_b;
   logic [3:0]  dc_b;
   logic        cs_b, tk_b;

   logic [2:0]  sel_c;
   logic [4:0]  dc_c;
   logic        cs_c, tk_c;

   int checks;
   int failures;
   logic [31:0] exp_q[$];

   clk_divider #(.WIDTH(32), .DEFAULT_SEL(24)) u_a (
      .clock(clock), .reset(reset), .enable(enable), .sel(sel_a),
      .divided_clocks(dc_a), .clk_sel(cs_a), .tick(tk_a));

   clk_divider #(.WIDTH(4), .DEFAULT_SEL(3)) u_b (
      .clock(clock), .reset(reset), .enable(enable), .sel(sel_b),
      .divided_clocks(dc_b), .clk_sel(cs_b), .tick(tk_b));

   clk_divider #(.WIDTH(5), .DEFAULT_SEL(4)) u_c (
      .clock(clock), .reset(reset), .enable(enable), .sel(sel_c),
      .divided_clocks(dc_c), .clk_sel(cs_c), .tick(tk_c));

   // clock block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // driver: advance one active edge and settle before sampling
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      enable   = 1'b1;
      sel_a    = 5'd0;
      sel_b    = 2'd3;
      sel_c    = 3'd7;

      // 1. reset held 3 cycles with enable high
      for (int k = 0; k < 3; k++) begin
         step();
         check("rst_cnt",  dc_a, 32'd0);
         check("rst_tick", {31'd0, tk_a}, 32'd0);
         check("rst_csel", {31'd0, cs_a}, 32'd0);
      end

      // 2. count 16 edges, sel=0: bit0 toggles, tick on every odd count
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         step();
         check($sformatf("cnt_%0d", k), dc_a, 32'(k));
         check($sformatf("bit0_%0d", k), {31'd0, cs_a}, 32'(k % 2));
         check($sformatf("tick0_%0d", k), {31'd0, tk_a}, 32'(k % 2));
      end
      check("bit3_at16", {31'd0, dc_a[3]}, 32'd0);

      // 3. sel=2 from zero: tick at counts 4, 12, 20 only
      reset = 1'b1;
      step();
      reset = 1'b0;
      sel_a = 5'd2;
      for (int k = 1; k <= 24; k++) exp_q.push_back(32'((k % 8) == 4));
      for (int k = 1; k <= 24; k++) begin
         logic [31:0] e;
         step();
         e = exp_q.pop_front();
         check($sformatf("tick2_%0d", k), {31'd0, tk_a}, e);
         check($sformatf("csel2_%0d", k), {31'd0, cs_a}, 32'((k >> 2) & 1));
      end

      // 4. enable hold at 5
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check("en_pre", dc_a, 32'd5);
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         check("en_hold", dc_a, 32'd5);
         check("en_tick", {31'd0, tk_a}, 32'd0);
         check("en_csel", {31'd0, cs_a}, 32'd1);
      end
      enable = 1'b1;
      step();
      check("en_resume", dc_a, 32'd6);

      // 5. WIDTH=4, sel=3 for 20 edges: wrap 15->0, tick at 8 only
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         check($sformatf("w4_cnt_%0d", k), {28'd0, dc_b}, 32'(k % 16));
         check($sformatf("w4_tick_%0d", k), {31'd0, tk_b}, 32'((k % 16) == 8));
      end

      // 6. mid-operation reset at 0x1F, then sel change 0->4 at count 3
      reset = 1'b1;
      step();
      reset = 1'b0;
      sel_a = 5'd0;
      for (int k = 0; k < 31; k++) step();
      check("mid_pre", dc_a, 32'h1F);
      reset = 1'b1;
      step();
      check("mid_cnt",  dc_a, 32'd0);
      check("mid_tick", {31'd0, tk_a}, 32'd0);
      check("mid_c_cnt", {27'd0, dc_c}, 32'd0);
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         check($sformatf("mid_tick0_%0d", k), {31'd0, tk_a}, 32'(k % 2));
      end
      sel_a = 5'd4;
      #1;
      check("sel_step_csel", {31'd0, cs_a}, 32'd0);
      for (int k = 4; k <= 16; k++) begin
         step();
         check($sformatf("sel4_tick_%0d", k), {31'd0, tk_a}, 32'(k == 16));
         check($sformatf("sel4_csel_%0d", k), {31'd0, cs_a}, 32'((k >> 4) & 1));
         // WIDTH=5 with sel=7 behaves as tap 4
         check($sformatf("clamp_tick_%0d", k), {31'd0, tk_c}, 32'(k == 16));
         check($sformatf("clamp_csel_%0d", k), {31'd0, cs_c}, 32'((k >> 4) & 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
